rpc2_ctrl_axi_wr_resp_merge: RTL
================================

Name: rpc2_ctrl_axi_wr_resp_merge

Overview:
Generalised AXI write-response generator for the RPC2/Xccela controller. It pairs each AWID FIFO entry with one or more sub-responses from the BDAT FIFO, because the IP may split one AXI write into several device transactions. It merges the sub-responses into one worst-case BRESP and returns it on the AXI B channel through a registered output buffer. Sits between the AWID/BDAT FIFOs and the AXI slave B port; no combinational path from bready to any FIFO read enable.

Parameters:
ID_WIDTH, 4, AXI BID width
CNT_WIDTH, 4, sub-response count field width; field value n means n+1 sub-responses (max 2^CNT_WIDTH)
OUT_DEPTH, 2, output buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
awid_fifo_empty  in  1  AWID FIFO empty
awid_fifo_rd_en  out  1  AWID FIFO pop; data valid the cycle after
awid_fifo_dout  in  ID_WIDTH+CNT_WIDTH  {id, sub_cnt}, id in MSBs
bdat_empty  in  1  BDAT FIFO empty
bdat_rd_en  out  1  BDAT FIFO pop; data valid the cycle after
bdat_dout  in  2  sub-response code
bid  out  ID_WIDTH  AXI BID
bresp  out  2  AXI BRESP
bvalid  out  1  AXI BVALID
bready  in  1  AXI BREADY
err_clr  in  1  clears wr_err_sticky
wr_err_sticky  out  1  set when any merged bresp >= 2'b10
busy  out  1  FSM not in IDLE or output buffer non-empty

Behaviour:
- Reset, synchronous, active-high: FSM=IDLE; all counters, accumulator and output buffer cleared. Outputs awid_fifo_rd_en=0, bdat_rd_en=0, bvalid=0, bid=0, bresp=0, wr_err_sticky=0, busy=0. Reset mid-operation discards the partial merge and buffered responses; external FIFOs are untouched.
- FSM states: IDLE, LOAD, COLLECT, PUSH.
- IDLE: if !awid_fifo_empty, assert awid_fifo_rd_en for exactly 1 cycle, then go to LOAD.
- LOAD: capture id and total = sub_cnt+1; clear issued, captured and acc=2'b00; go to COLLECT.
- COLLECT: bdat_rd_en = !bdat_empty && (issued < total). Back-to-back pops are allowed.
  - A pop at cycle t is captured at t+1: acc = max(acc, bdat_dout) (numeric max: DECERR>SLVERR>EXOKAY>OKAY); captured++.
  - When the capture makes captured==total, go to PUSH next cycle.
- PUSH: if the output buffer is not full (registered full flag; a same-cycle pop does not free space), write {id, acc} and go to IDLE. Otherwise hold.
- Output buffer: OUT_DEPTH FIFO.
  - bvalid = !empty; bid/bresp = head entry, registered.
  - Pop on bvalid&&bready.
  - bid/bresp hold stable while bvalid && !bready.
- Counter widths: issued/captured are CNT_WIDTH+1 bits, so total=2^CNT_WIDTH does not wrap.
- Minimum latency: awid pop (T0) -> LOAD T1 -> bdat pop T2 -> capture T3 -> PUSH T4 -> bvalid T5. Steady-state single-sub-response throughput is 1 response / 5 cycles.
- wr_err_sticky: set on PUSH write with acc>=2'b10. Clear on err_clr, and a simultaneous set wins. Updates 1 cycle after the event.
- bdat_empty while sub-responses are outstanding: stall in COLLECT indefinitely with no timeout.
- bready held low: the buffer fills, PUSH stalls, and no further FIFO pops occur.
- AXI ordering: responses are issued in AWID FIFO order.

Decomposition:
- Package rpc2_ctrl_axi_pkg: BRESP codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), FSM state encodings, resp-max function.
- One sub-module: rpc2_ctrl_axi_b_out_fifo. Parametrised {ID_WIDTH+2} x OUT_DEPTH register FIFO with registered full/empty, synchronous active-high reset.

Test Plan:
- Single write: awid {id=4'h3, cnt=0}, bdat 2'b00, bready=1 -> bvalid at T5 with bid=3, bresp=0, for 1 cycle; wr_err_sticky=0.
- Split write: awid {id=4'h5, cnt=3}, bdat sequence 0,0,2,0 -> exactly 4 bdat pops, one B beat bid=5, bresp=2'b10, wr_err_sticky=1; then err_clr -> 0.
- Max-count: cnt=4'hF with 16 bdat entries, including one 2'b11 -> 16 pops, bresp=2'b11, no counter wrap, only 1 AWID pop.
- Backpressure: 4 single writes (ids 1..4), bready=0 for 20 cycles -> bvalid=1 with bid=1 stable, exactly OUT_DEPTH+1 AWID pops. Then bready=1 -> bids 1,2,3,4 in order, no loss or duplication.
- Starvation: awid present, bdat_empty=1 for 10 cycles -> bdat_rd_en=0 after issued==captured, FSM in COLLECT, busy=1, bvalid=0. Fill bdat -> response completes.
- Reset mid-merge: assert reset in COLLECT after 2 of 4 captures -> next cycle all outputs 0, FSM IDLE, a buffered response is dropped, bvalid=0.

Source files
------------

// File: rtl/rpc2_ctrl_axi_pkg.sv
// Shared definitions for the RPC2 controller AXI write-response path:
// BRESP codes, merge FSM states and response-merge helpers.
package rpc2_ctrl_axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_PUSH    = 2'd3
    } wr_state_e;

    // The codes are ordered by severity, so a numeric max is the worst case.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic resp_is_err(input logic [1:0] r);
        return r >= 2'(RESP_SLVERR);
    endfunction

endpackage

// File: rtl/rpc2_ctrl_axi_b_out_fifo.sv
// Small register FIFO holding merged {bid, bresp} entries for the AXI B channel.
// Full and empty are registered, so a pop never frees space in the same cycle.
module rpc2_ctrl_axi_b_out_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && !full_q;
        do_rd    = rd_en && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/rpc2_ctrl_axi_wr_resp_merge.sv
// AXI write-response generator: pairs each AWID entry with its sub-responses,
// merges them into one worst-case BRESP and queues it for the B channel.
module rpc2_ctrl_axi_wr_resp_merge
    import rpc2_ctrl_axi_pkg::*;
#(
    parameter int ID_WIDTH  = 4,
    parameter int CNT_WIDTH = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          awid_fifo_empty,
    output logic                          awid_fifo_rd_en,
    input  logic [ID_WIDTH+CNT_WIDTH-1:0] awid_fifo_dout,
    input  logic                          bdat_empty,
    output logic                          bdat_rd_en,
    input  logic [1:0]                    bdat_dout,
    output logic [ID_WIDTH-1:0]           bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic                          err_clr,
    output logic                          wr_err_sticky,
    output logic                          busy
);

    // One extra bit so a full 2^CNT_WIDTH sub-response count does not wrap.
    localparam int CW = CNT_WIDTH + 1;

    wr_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [CW-1:0]         total_q, total_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         captured_q, captured_d;
    logic [1:0]            acc_q, acc_d;
    logic                  cap_pend_q, cap_pend_d;
    logic                  sticky_q, sticky_d;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [CNT_WIDTH-1:0]  aw_cnt;
    logic                  aw_pop, bd_pop, push;
    logic                  buf_full, buf_empty;
    logic [ID_WIDTH+1:0]   buf_head;

    assign {aw_id, aw_cnt} = awid_fifo_dout;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        total_d    = total_q;
        issued_d   = issued_q;
        captured_d = captured_q;
        acc_d      = acc_q;
        aw_pop     = 1'b0;
        bd_pop     = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!awid_fifo_empty) begin
                    aw_pop  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                id_d       = aw_id;
                total_d    = {1'b0, aw_cnt} + CW'(1);
                issued_d   = '0;
                captured_d = '0;
                acc_d      = 2'(RESP_OKAY);
                state_d    = ST_COLLECT;
            end
            ST_COLLECT: begin
                bd_pop = !bdat_empty && (issued_q < total_q);
                if (bd_pop) begin
                    issued_d = issued_q + CW'(1);
                end
                // A pop issued last cycle presents its data on bdat_dout now.
                if (cap_pend_q) begin
                    acc_d      = resp_max(acc_q, bdat_dout);
                    captured_d = captured_q + CW'(1);
                    if (captured_d == total_q) begin
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                if (!buf_full) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cap_pend_d = bd_pop;
        sticky_d   = (push && resp_is_err(acc_q)) || (sticky_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            total_q    <= '0;
            issued_q   <= '0;
            captured_q <= '0;
            acc_q      <= '0;
            cap_pend_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            total_q    <= total_d;
            issued_q   <= issued_d;
            captured_q <= captured_d;
            acc_q      <= acc_d;
            cap_pend_q <= cap_pend_d;
            sticky_q   <= sticky_d;
        end
    end

    rpc2_ctrl_axi_b_out_fifo #(
        .WIDTH (ID_WIDTH + 2),
        .DEPTH (OUT_DEPTH)
    ) u_b_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({id_q, acc_q}),
        .rd_en   (bvalid && bready),
        .rd_data (buf_head),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // FIFO pops are held off while reset is asserted so nothing is consumed and lost.
    assign awid_fifo_rd_en = aw_pop && !reset;
    assign bdat_rd_en      = bd_pop && !reset;
    assign bvalid          = !buf_empty;
    assign {bid, bresp}    = buf_head;
    assign wr_err_sticky   = sticky_q;
    assign busy            = (state_q != ST_IDLE) || !buf_empty;

endmodule
